bp_update_controller: RTL and testbench

BP_UPDATE_CONTROLLER -- requirements
Module: bp_update_controller

---
 rtl/bp_update_controller_pkg.sv | 14 +
 rtl/bp_update_controller.sv | 163 ++++++++++++++++
 tb/tb_bp_update_controller.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_update_controller_pkg.sv
// Shared types for the branch-predictor table update controller.
//   bp_state_e : controller FSM states (power-on sweep, idle, requested sweep)
//   TargetW    : width of a branch-target entry
package bp_update_controller_pkg;

    localparam int unsigned TargetW = 32;

    typedef enum logic [1:0] {
        StInitSweep = 2'd0,
        StIdle      = 2'd1,
        StSweep     = 2'd2
    } bp_state_e;

endpackage

// File: rtl/bp_update_controller.sv
// Branch-predictor table update controller. Sits in front of the tag and target RAM
// write ports, forwarding execute-stage updates and sweeping the tag banks to zero
// (invalid) after reset or on a flush request.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   flush_req                : request full table invalidation
//   flush_ack                : one-cycle pulse when a requested sweep completes
//   busy                     : sweep in progress, predictions must be ignored
//   upd_valid / upd_ready    : update handshake (ready is always 1)
//   upd_way .. upd_target    : update record (one-hot way, line address, tag, target)
//   tbl_tag_we .. tbl_target : registered write port to the tag and target RAMs
module bp_update_controller
    import bp_update_controller_pkg::*;
#(
    parameter int unsigned ENTRIES = 512,
    parameter int unsigned WAYS    = 2,
    parameter int unsigned ENTRY_W = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_req,
    output logic                       flush_ack,
    output logic                       busy,
    input  logic                       upd_valid,
    output logic                       upd_ready,
    input  logic [WAYS-1:0]            upd_way,
    input  logic [$clog2(ENTRIES)-1:0] upd_addr,
    input  logic [ENTRY_W-1:0]         upd_tag_data,
    input  logic                       upd_target_we,
    input  logic [TargetW-1:0]         upd_target,
    output logic [WAYS-1:0]            tbl_tag_we,
    output logic [WAYS-1:0]            tbl_target_we,
    output logic [$clog2(ENTRIES)-1:0] tbl_addr,
    output logic [ENTRY_W-1:0]         tbl_tag_data,
    output logic [TargetW-1:0]         tbl_target
);

    localparam int unsigned AddrW = $clog2(ENTRIES);

    typedef struct packed {
        logic [WAYS-1:0]    way;
        logic [AddrW-1:0]   addr;
        logic [ENTRY_W-1:0] tag_data;
        logic               target_we;
        logic [TargetW-1:0] target;
    } bp_update_t;

    bp_update_t upd;
    assign upd = '{way: upd_way, addr: upd_addr, tag_data: upd_tag_data,
                   target_we: upd_target_we, target: upd_target};

    // Updates are never back-pressured; during a sweep they are simply dropped.
    assign upd_ready = 1'b1;

    bp_state_e          state_q, state_d;
    logic [AddrW-1:0]   cnt_q, cnt_d;     // next sweep address to write
    logic               last_q, last_d;   // final sweep write has been issued
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic [WAYS-1:0]    tag_we_q, tag_we_d;
    logic [WAYS-1:0]    target_we_q, target_we_d;
    logic [AddrW-1:0]   addr_q, addr_d;
    logic [ENTRY_W-1:0] tag_data_q, tag_data_d;
    logic [TargetW-1:0] target_q, target_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        busy_d      = busy_q;
        ack_d       = 1'b0;
        tag_we_d    = '0;
        target_we_d = '0;
        addr_d      = addr_q;
        tag_data_d  = tag_data_q;
        target_d    = target_q;

        unique case (state_q)
            StIdle: begin
                if (flush_req) begin
                    // Flush wins over a simultaneous update; write addr 0 on this edge.
                    state_d    = StSweep;
                    busy_d     = 1'b1;
                    tag_we_d   = '1;
                    addr_d     = '0;
                    tag_data_d = '0;
                    cnt_d      = AddrW'(1);
                    last_d     = 1'b0;
                end else if (upd_valid) begin
                    tag_we_d    = upd.way;
                    target_we_d = upd.target_we ? upd.way : '0;
                    addr_d      = upd.addr;
                    tag_data_d  = upd.tag_data;
                    target_d    = upd.target;
                end
            end
            StInitSweep, StSweep: begin
                if (flush_req) begin
                    // Restart from 0; a power-on sweep becomes a requested one.
                    state_d    = StSweep;
                    tag_we_d   = '1;
                    addr_d     = '0;
                    tag_data_d = '0;
                    cnt_d      = AddrW'(1);
                    last_d     = 1'b0;
                end else if (last_q) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    ack_d   = (state_q == StSweep);
                    last_d  = 1'b0;
                end else begin
                    tag_we_d   = '1;
                    addr_d     = cnt_q;
                    tag_data_d = '0;
                    // Counter wraps after the final write, but last_q stops the sweep.
                    cnt_d      = cnt_q + AddrW'(1);
                    last_d     = (cnt_q == AddrW'(ENTRIES - 1));
                end
            end
            default: begin
                state_d = StInitSweep;
                busy_d  = 1'b1;
                cnt_d   = '0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StInitSweep;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b1;
            ack_q       <= 1'b0;
            tag_we_q    <= '0;
            target_we_q <= '0;
            addr_q      <= '0;
            tag_data_q  <= '0;
            target_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            tag_we_q    <= tag_we_d;
            target_we_q <= target_we_d;
            addr_q      <= addr_d;
            tag_data_q  <= tag_data_d;
            target_q    <= target_d;
        end
    end

    assign flush_ack     = ack_q;
    assign busy          = busy_q;
    assign tbl_tag_we    = tag_we_q;
    assign tbl_target_we = target_we_q;
    assign tbl_addr      = addr_q;
    assign tbl_tag_data  = tag_data_q;
    assign tbl_target    = target_q;

endmodule

// File: tb/tb_bp_update_controller.sv
// Directed testbench for bp_update_controller with ENTRIES=8, WAYS=2, ENTRY_W=24.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bp_update_controller;

    localparam int unsigned ENTRIES = 8;
    localparam int unsigned WAYS    = 2;
    localparam int unsigned ENTRY_W = 24;

    logic                       clk;
    logic                       rst;
    logic                       flush_req;
    logic                       flush_ack;
    logic                       busy;
    logic                       upd_valid;
    logic                       upd_ready;
    logic [WAYS-1:0]            upd_way;
    logic [$clog2(ENTRIES)-1:0] upd_addr;
    logic [ENTRY_W-1:0]         upd_tag_data;
    logic                       upd_target_we;
    logic [31:0]                upd_target;
    logic [WAYS-1:0]            tbl_tag_we;
    logic [WAYS-1:0]            tbl_target_we;
    logic [$clog2(ENTRIES)-1:0] tbl_addr;
    logic [ENTRY_W-1:0]         tbl_tag_data;
    logic [31:0]                tbl_target;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acks   = 0;

    bp_update_controller #(
        .ENTRIES(ENTRIES),
        .WAYS   (WAYS),
        .ENTRY_W(ENTRY_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_req    (flush_req),
        .flush_ack    (flush_ack),
        .busy         (busy),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_way      (upd_way),
        .upd_addr     (upd_addr),
        .upd_tag_data (upd_tag_data),
        .upd_target_we(upd_target_we),
        .upd_target   (upd_target),
        .tbl_tag_we   (tbl_tag_we),
        .tbl_target_we(tbl_target_we),
        .tbl_addr     (tbl_addr),
        .tbl_tag_data (tbl_tag_data),
        .tbl_target   (tbl_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (flush_ack) n_acks++;
    endtask

    task automatic check_sweep(input int k);
        check($sformatf("sweep_tag_we[%0d]", k), 64'(tbl_tag_we), 64'h3);
        check($sformatf("sweep_addr[%0d]", k), 64'(tbl_addr), 64'(k));
        check($sformatf("sweep_tag_data[%0d]", k), 64'(tbl_tag_data), 64'h0);
        check($sformatf("sweep_target_we[%0d]", k), 64'(tbl_target_we), 64'h0);
        check($sformatf("sweep_busy[%0d]", k), 64'(busy), 64'h1);
        check($sformatf("sweep_ack[%0d]", k), 64'(flush_ack), 64'h0);
    endtask

    task automatic check_done(input string tag, input logic exp_ack);
        check({tag, "_busy"}, 64'(busy), 64'h0);
        check({tag, "_tag_we"}, 64'(tbl_tag_we), 64'h0);
        check({tag, "_ack"}, 64'(flush_ack), 64'(exp_ack));
    endtask

    initial begin
        rst           = 1'b0;
        flush_req     = 1'b0;
        upd_valid     = 1'b0;
        upd_way       = '0;
        upd_addr      = '0;
        upd_tag_data  = '0;
        upd_target_we = 1'b0;
        upd_target    = '0;

        // Reset values, held across a couple of edges.
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'h1);
        check("rst_ack", 64'(flush_ack), 64'h0);
        check("rst_tag_we", 64'(tbl_tag_we), 64'h0);
        check("rst_target_we", 64'(tbl_target_we), 64'h0);
        check("rst_addr", 64'(tbl_addr), 64'h0);
        check("rst_tag_data", 64'(tbl_tag_data), 64'h0);
        check("rst_target", 64'(tbl_target), 64'h0);
        check("upd_ready", 64'(upd_ready), 64'h1);

        // Power-on sweep: addr 0..7, then idle with no ack.
        rst = 1'b1;
        n_acks = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_sweep(k);
        end
        tick();
        check_done("init_done", 1'b0);
        tick();
        check("init_ack_count", 64'(n_acks), 64'h0);

        // Update with target write.
        upd_valid     = 1'b1;
        upd_way       = 2'b10;
        upd_addr      = 3'd5;
        upd_tag_data  = 24'h80_1234;
        upd_target_we = 1'b1;
        upd_target    = 32'h8000_0040;
        tick();
        upd_valid = 1'b0;
        check("upd_tag_we", 64'(tbl_tag_we), 64'h2);
        check("upd_target_we", 64'(tbl_target_we), 64'h2);
        check("upd_addr", 64'(tbl_addr), 64'h5);
        check("upd_tag_data", 64'(tbl_tag_data), 64'h80_1234);
        check("upd_target", 64'(tbl_target), 64'h8000_0040);
        check("upd_busy", 64'(busy), 64'h0);
        tick();
        check("idle_tag_we", 64'(tbl_tag_we), 64'h0);
        check("idle_target_we", 64'(tbl_target_we), 64'h0);

        // Update without target write.
        upd_valid     = 1'b1;
        upd_way       = 2'b01;
        upd_addr      = 3'd2;
        upd_tag_data  = 24'h8a_bcde;
        upd_target_we = 1'b0;
        tick();
        upd_valid = 1'b0;
        check("upd2_tag_we", 64'(tbl_tag_we), 64'h1);
        check("upd2_target_we", 64'(tbl_target_we), 64'h0);
        check("upd2_addr", 64'(tbl_addr), 64'h2);
        check("upd2_tag_data", 64'(tbl_tag_data), 64'h8a_bcde);

        // Requested flush: writes in T+1..T+8, ack only in T+9.
        flush_req = 1'b1;
        n_acks = 0;
        tick();
        flush_req = 1'b0;
        check_sweep(0);
        for (int k = 1; k < 8; k++) begin
            tick();
            check_sweep(k);
        end
        tick();
        check_done("flush_done", 1'b1);
        tick();
        check("flush_ack_low", 64'(flush_ack), 64'h0);
        check("flush_ack_count", 64'(n_acks), 64'h1);

        // Flush again at addr 4 restarts the sweep; a single ack at the end.
        flush_req = 1'b1;
        n_acks = 0;
        tick();
        flush_req = 1'b0;
        check_sweep(0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_sweep(k);
        end
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check_sweep(0);
        for (int k = 1; k < 8; k++) begin
            tick();
            check_sweep(k);
        end
        tick();
        check_done("restart_done", 1'b1);
        tick();
        check("restart_ack_count", 64'(n_acks), 64'h1);

        // Update one cycle before flush is still written, then flush+update together.
        upd_valid     = 1'b1;
        upd_way       = 2'b01;
        upd_addr      = 3'd3;
        upd_tag_data  = 24'h81_1111;
        upd_target_we = 1'b1;
        upd_target    = 32'h1234_5678;
        tick();
        check("pre_flush_upd_tag_we", 64'(tbl_tag_we), 64'h1);
        check("pre_flush_upd_addr", 64'(tbl_addr), 64'h3);
        // Update held valid with flush and throughout the sweep: all dropped.
        upd_addr  = 3'd6;
        flush_req = 1'b1;
        n_acks = 0;
        tick();
        flush_req = 1'b0;
        check_sweep(0);
        for (int k = 1; k < 8; k++) begin
            tick();
            check_sweep(k);
        end
        tick();
        check_done("drop_done", 1'b1);
        check("drop_target_we", 64'(tbl_target_we), 64'h0);
        upd_valid = 1'b0;
        tick();
        check("drop_ack_count", 64'(n_acks), 64'h1);

        // Reset mid-sweep at addr 3: immediate clear, full silent sweep after release.
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int k = 1; k <= 3; k++) tick();
        check("pre_rst_addr", 64'(tbl_addr), 64'h3);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_tag_we", 64'(tbl_tag_we), 64'h0);
        check("mid_rst_target_we", 64'(tbl_target_we), 64'h0);
        check("mid_rst_busy", 64'(busy), 64'h1);
        check("mid_rst_ack", 64'(flush_ack), 64'h0);
        check("mid_rst_addr", 64'(tbl_addr), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        n_acks = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_sweep(k);
        end
        tick();
        check_done("rst_sweep_done", 1'b0);
        tick();
        check("rst_sweep_ack_count", 64'(n_acks), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
